// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-2 demux.
// Select encodings and default data width.
package demux_pkg;

  localparam int DEFAULT_DATA_W = 1;

  localparam logic SEL_CH0 = 1'b0;
  localparam logic SEL_CH1 = 1'b1;

endpackage

// File: rtl/demux_out_reg.sv
// One output channel register: data plus valid.
// Asynchronous active-high clear.
module demux_out_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_d,
  input  logic              valid_d,
  output logic [DATA_W-1:0] data_q,
  output logic              valid_q
);

  // Capture next data/valid each edge; reset clears immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demux: steers i to y0 or y1.
// Unselected channel and idle cycles drive zeros.
module demux_1to2_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i,
  input  logic              s,
  input  logic              in_valid,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic              y0_valid,
  output logic              y1_valid
);

  logic [DATA_W-1:0] y0_d;
  logic [DATA_W-1:0] y1_d;
  logic              y0_valid_d;
  logic              y1_valid_d;

  // Route the sample to exactly one channel; zero everything else.
  always_comb begin
    y0_d       = '0;
    y1_d       = '0;
    y0_valid_d = 1'b0;
    y1_valid_d = 1'b0;
    if (in_valid) begin
      if (s == SEL_CH1) begin
        y1_d       = i;
        y1_valid_d = 1'b1;
      end else begin
        y0_d       = i;
        y0_valid_d = 1'b1;
      end
    end
  end

  demux_out_reg #(
    .DATA_W (DATA_W)
  ) u_ch0 (
    .clk     (clk),
    .rst     (rst),
    .data_d  (y0_d),
    .valid_d (y0_valid_d),
    .data_q  (y0),
    .valid_q (y0_valid)
  );

  demux_out_reg #(
    .DATA_W (DATA_W)
  ) u_ch1 (
    .clk     (clk),
    .rst     (rst),
    .data_d  (y1_d),
    .valid_d (y1_valid_d),
    .data_q  (y1),
    .valid_q (y1_valid)
  );

  // An unknown select on a qualified cycle has no defined route.
  a_sel_known: assert property (
    @(posedge clk) disable iff (rst)
    in_valid |-> !$isunknown(s)
  );

  // Channels are exclusive.
  a_excl: assert property (
    @(posedge clk) disable iff (rst)
    !(y0_valid && y1_valid)
  );

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Directed bench for demux_1to2_reg.
// Drives a 1-bit and an 8-bit instance side by side.
module tb_demux_1to2_reg;

  logic       clk;
  logic       rst;
  logic       s;
  logic       in_valid;
  logic       i1;
  logic [7:0] i8;

  logic       a_y0, a_y1, a_v0, a_v1;
  logic [7:0] b_y0, b_y1;
  logic       b_v0, b_v1;

  int errors;
  int checks;

  demux_1to2_reg #(.DATA_W(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .i        (i1),
    .s        (s),
    .in_valid (in_valid),
    .y0       (a_y0),
    .y1       (a_y1),
    .y0_valid (a_v0),
    .y1_valid (a_v1)
  );

  demux_1to2_reg #(.DATA_W(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .i        (i8),
    .s        (s),
    .in_valid (in_valid),
    .y0       (b_y0),
    .y1       (b_y1),
    .y0_valid (b_v0),
    .y1_valid (b_v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i1 = 1'b1;
    i8 = 8'h01;
    s = 1'b1;
    in_valid = 1'b1;
    #2;
    checks++;
    if ({a_y0, a_y1, a_v0, a_v1} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async_w1 got=%b exp=%b",
               {a_y0, a_y1, a_v0, a_v1}, 4'b0000);
    end
    checks++;
    if ({b_y0, b_y1, b_v0, b_v1} !== 18'h0) begin
      errors++;
      $display("FAIL rst_async_w8 got=%h exp=%h",
               {b_y0, b_y1, b_v0, b_v1}, 18'h0);
    end
    step();
    checks++;
    if ({b_y0, b_y1, b_v0, b_v1} !== 18'h0) begin
      errors++;
      $display("FAIL rst_held_edge got=%h exp=%h",
               {b_y0, b_y1, b_v0, b_v1}, 18'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if ({a_y0, a_y1, a_v0, a_v1} !== 4'b0101) begin
      errors++;
      $display("FAIL rst_release_w1 got=%b exp=%b",
               {a_y0, a_y1, a_v0, a_v1}, 4'b0101);
    end
    checks++;
    if ({b_y0, b_y1, b_v0, b_v1} !== {8'h00, 8'h01, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_release_w8 got=%h exp=%h",
               {b_y0, b_y1, b_v0, b_v1}, {8'h00, 8'h01, 1'b0, 1'b1});
    end
  endtask

  task automatic test_ch0();
    in_valid = 1'b1;
    s = 1'b0;
    i1 = 1'b0;
    step();
    checks++;
    if ({a_y0, a_y1, a_v0, a_v1} !== 4'b0010) begin
      errors++;
      $display("FAIL ch0_zero got=%b exp=%b",
               {a_y0, a_y1, a_v0, a_v1}, 4'b0010);
    end
    i1 = 1'b1;
    step();
    checks++;
    if ({a_y0, a_y1, a_v0, a_v1} !== 4'b1010) begin
      errors++;
      $display("FAIL ch0_one got=%b exp=%b",
               {a_y0, a_y1, a_v0, a_v1}, 4'b1010);
    end
  endtask

  task automatic test_ch1();
    in_valid = 1'b1;
    s = 1'b1;
    i1 = 1'b0;
    step();
    checks++;
    if ({a_y0, a_y1, a_v0, a_v1} !== 4'b0001) begin
      errors++;
      $display("FAIL ch1_zero got=%b exp=%b",
               {a_y0, a_y1, a_v0, a_v1}, 4'b0001);
    end
    i1 = 1'b1;
    step();
    checks++;
    if ({a_y0, a_y1, a_v0, a_v1} !== 4'b0101) begin
      errors++;
      $display("FAIL ch1_one got=%b exp=%b",
               {a_y0, a_y1, a_v0, a_v1}, 4'b0101);
    end
  endtask

  task automatic test_alternate();
    logic [7:0]  vals [4];
    logic [17:0] exp;
    vals[0] = 8'hA5;
    vals[1] = 8'h3C;
    vals[2] = 8'hFF;
    vals[3] = 8'h01;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i8 = vals[k];
      s = (k % 2) == 1;
      step();
      if ((k % 2) == 1) exp = {8'h00, vals[k], 1'b0, 1'b1};
      else              exp = {vals[k], 8'h00, 1'b1, 1'b0};
      checks++;
      if ({b_y0, b_y1, b_v0, b_v1} !== exp) begin
        errors++;
        $display("FAIL alt_%0d got=%h exp=%h",
                 k, {b_y0, b_y1, b_v0, b_v1}, exp);
      end
    end
  endtask

  task automatic test_gap();
    in_valid = 1'b1;
    s = 1'b0;
    i8 = 8'hFF;
    step();
    checks++;
    if ({b_y0, b_y1, b_v0, b_v1} !== {8'hFF, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL gap_on got=%h exp=%h",
               {b_y0, b_y1, b_v0, b_v1}, {8'hFF, 8'h00, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    step();
    checks++;
    if ({b_y0, b_y1, b_v0, b_v1} !== 18'h0) begin
      errors++;
      $display("FAIL gap_off got=%h exp=%h",
               {b_y0, b_y1, b_v0, b_v1}, 18'h0);
    end
  endtask

  task automatic test_midstream_reset();
    in_valid = 1'b1;
    s = 1'b0;
    i8 = 8'h11;
    step();
    checks++;
    if ({b_y0, b_y1, b_v0, b_v1} !== {8'h11, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_pre got=%h exp=%h",
               {b_y0, b_y1, b_v0, b_v1}, {8'h11, 8'h00, 1'b1, 1'b0});
    end
    s = 1'b1;
    i8 = 8'h22;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({b_y0, b_y1, b_v0, b_v1} !== 18'h0) begin
      errors++;
      $display("FAIL mid_clear_w8 got=%h exp=%h",
               {b_y0, b_y1, b_v0, b_v1}, 18'h0);
    end
    checks++;
    if ({a_y0, a_y1, a_v0, a_v1} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_clear_w1 got=%b exp=%b",
               {a_y0, a_y1, a_v0, a_v1}, 4'b0000);
    end
    #1;
    rst = 1'b0;
    step();
    checks++;
    if ({b_y0, b_y1, b_v0, b_v1} !== {8'h00, 8'h22, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_resume1 got=%h exp=%h",
               {b_y0, b_y1, b_v0, b_v1}, {8'h00, 8'h22, 1'b0, 1'b1});
    end
    s = 1'b0;
    i8 = 8'h33;
    step();
    checks++;
    if ({b_y0, b_y1, b_v0, b_v1} !== {8'h33, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_resume2 got=%h exp=%h",
               {b_y0, b_y1, b_v0, b_v1}, {8'h33, 8'h00, 1'b1, 1'b0});
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    s = 1'b0;
    in_valid = 1'b0;
    i1 = 1'b0;
    i8 = 8'h00;
    test_reset();
    test_ch0();
    test_ch1();
    test_alternate();
    test_gap();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux_1to2_reg.md
Name: demux_1to2_reg

Overview:
- Registered 1-to-2 demultiplexer. Routes data input i to y0 when select s=0, or to y1 when s=1.
- The unselected output is driven to zero.
- Output stage is registered: one-cycle latency, clean glitch-free outputs for downstream logic.
- Used as a generic steering element in datapaths that fan one source out to two sinks.

Parameters:
- DATA_W, 1, width of i, y0 and y1 in bits (must be >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- i  input  DATA_W  data to be steered
- s  input  1  select: 0 routes i to y0, 1 routes i to y1
- in_valid  input  1  qualifies i/s this cycle
- y0  output  DATA_W  channel-0 data (registered)
- y1  output  DATA_W  channel-1 data (registered)
- y0_valid  output  1  channel-0 data valid (registered)
- y1_valid  output  1  channel-1 data valid (registered)

Behaviour:
- Reset: while rst=1, y0, y1, y0_valid and y1_valid are all 0, asynchronously and immediately. Outputs stay 0 until the first rising clk edge after rst deasserts.
- Each rising clk edge with rst=0 and in_valid=1:
  - s=0: y0<=i, y1<=0, y0_valid<=1, y1_valid<=0.
  - s=1: y0<=0, y1<=i, y0_valid<=0, y1_valid<=1.
- Each rising clk edge with rst=0 and in_valid=0: y0<=0, y1<=0, y0_valid<=0, y1_valid<=0. Values are not held.
- Latency: exactly 1 cycle from input sample to output. No combinational path from any input to any output.
- Throughput: one transfer per cycle. No backpressure and no ready signal.
- Routing is exclusive: y0_valid and y1_valid are never both 1. The non-selected data output is always all-zero.
- i=0 with in_valid=1 is a valid transfer. The selected valid asserts even though its data is zero.
- Select changing every cycle: each cycle is routed independently with no inter-cycle state.
- Reset asserted mid-stream: outputs clear at once and the in-flight sample is discarded. The first transfer after release appears one cycle after its sample edge.
- X/Z on s while in_valid=1 is not a legal input. Behaviour is unspecified, and a simulation assertion flags it.
- Widths are exact. No truncation or extension of i.

Decomposition:
- Shared package demux_pkg:
  - DEFAULT_DATA_W = 1.
  - Named constants SEL_CH0 = 1'b0 and SEL_CH1 = 1'b1.
- One sub-module, demux_out_reg: a DATA_W-wide data plus valid register with asynchronous active-high clear. It is instantiated twice, once per output channel.
- Top level holds only the steering logic: computing each channel's next data and next valid from i, s and in_valid.

Test Plan:
- Reset: assert rst with i=1, s=1, in_valid=1 -> y0=0, y1=0, both valids 0 immediately. Release rst; after one edge -> y1=1, y1_valid=1, y0=0.
- Channel 0 (DATA_W=1), in_valid=1: i=0,s=0 -> y0=0,y1=0,y0_valid=1,y1_valid=0. Then i=1,s=0 -> y0=1,y1=0,y0_valid=1 one cycle later.
- Channel 1 (DATA_W=1), in_valid=1: i=0,s=1 -> y0=0,y1=0,y1_valid=1. Then i=1,s=1 -> y0=0,y1=1,y1_valid=1, one cycle after sampling.
- Alternating select (DATA_W=8): s toggles every cycle with i=0xA5,0x3C,0xFF,0x01 -> outputs y0=0xA5, y1=0x3C, y0=0xFF, y1=0x01 on consecutive cycles, the other channel 0 each time. Exclusivity assertion never fires.
- in_valid gaps: i=0xFF, s=0, in_valid=1 then in_valid=0 -> y0=0xFF,y0_valid=1 for one cycle, then y0=0,y0_valid=0.
- Mid-stream reset: during an alternating stream, assert rst asynchronously between edges -> all outputs 0 before the next edge. After release, the stream resumes with 1-cycle latency.
